// File: rtl/ex_operand_stage.sv
// ID/EX stage register with operand select and EX/MEM, MEM/WB forwarding.
// Feeds the ALU one cycle after ID and raises load_use when the hazard unit must stall.
module ex_operand_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            stall,
  input  logic            flush,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [4:0]      id_rd,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [1:0]      id_alusrc_a,
  input  logic            id_alusrc_b,
  input  logic [3:0]      id_aluctrl,
  input  logic [2:0]      id_aluctrl1,
  input  logic            id_regwrite,
  input  logic            id_memread,
  input  logic            id_memwrite,
  input  logic            exmem_regwrite,
  input  logic [4:0]      exmem_rd,
  input  logic [XLEN-1:0] exmem_result,
  input  logic            memwb_regwrite,
  input  logic [4:0]      memwb_rd,
  input  logic [XLEN-1:0] memwb_result,
  output logic [XLEN-1:0] a,
  output logic [XLEN-1:0] b,
  output logic [4:0]      shamt,
  output logic [3:0]      aluctrl,
  output logic [2:0]      aluctrl1,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [4:0]      ex_rd,
  output logic [XLEN-1:0] ex_store_data,
  output logic            ex_regwrite,
  output logic            ex_memread,
  output logic            ex_memwrite,
  output logic            load_use
);

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [1:0]      alusrc_a;
    logic            alusrc_b;
    logic [3:0]      aluctrl;
    logic [2:0]      aluctrl1;
    logic            regwrite;
    logic            memread;
    logic            memwrite;
  } stage_t;

  stage_t stage_d, stage_q;

  always_comb begin
    stage_d = stage_q;
    if (flush) begin
      stage_d = '0;
    end else if (!stall) begin
      stage_d.valid    = id_valid;
      stage_d.pc       = id_pc;
      stage_d.rs1      = id_rs1;
      stage_d.rs2      = id_rs2;
      stage_d.rd       = id_rd;
      stage_d.rs1_data = id_rs1_data;
      stage_d.rs2_data = id_rs2_data;
      stage_d.imm      = id_imm;
      stage_d.alusrc_a = id_alusrc_a;
      stage_d.alusrc_b = id_alusrc_b;
      // A non-valid slot must never write state or resolve a branch.
      stage_d.aluctrl  = id_valid ? id_aluctrl  : 4'b0000;
      stage_d.aluctrl1 = id_valid ? id_aluctrl1 : 3'b000;
      stage_d.regwrite = id_valid & id_regwrite;
      stage_d.memread  = id_valid & id_memread;
      stage_d.memwrite = id_valid & id_memwrite;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) stage_q <= '0;
    else       stage_q <= stage_d;
  end

  // Newest producer wins; x0 is hardwired zero so it is never forwarded.
  function automatic logic [XLEN-1:0] fwd_sel(
    input logic [4:0]      rs,
    input logic [XLEN-1:0] rdata,
    input logic            em_we,
    input logic [4:0]      em_rd,
    input logic [XLEN-1:0] em_res,
    input logic            mw_we,
    input logic [4:0]      mw_rd,
    input logic [XLEN-1:0] mw_res
  );
    if (em_we && em_rd != 5'd0 && em_rd == rs)      return em_res;
    else if (mw_we && mw_rd != 5'd0 && mw_rd == rs) return mw_res;
    else                                            return rdata;
  endfunction

  logic [XLEN-1:0] fwd1, fwd2;

  always_comb begin
    fwd1 = fwd_sel(stage_q.rs1, stage_q.rs1_data, exmem_regwrite, exmem_rd, exmem_result,
                   memwb_regwrite, memwb_rd, memwb_result);
    fwd2 = fwd_sel(stage_q.rs2, stage_q.rs2_data, exmem_regwrite, exmem_rd, exmem_result,
                   memwb_regwrite, memwb_rd, memwb_result);
  end

  always_comb begin
    unique case (stage_q.alusrc_a)
      2'b00:   a = fwd1;
      2'b01:   a = stage_q.pc;
      default: a = '0;
    endcase
    // Branches compare rs1 against rs2, so the immediate select is ignored.
    if (stage_q.aluctrl1 != 3'b000) b = fwd2;
    else                            b = stage_q.alusrc_b ? stage_q.imm : fwd2;
  end

  assign shamt         = b[4:0];
  assign ex_store_data = fwd2;
  assign aluctrl       = stage_q.aluctrl;
  assign aluctrl1      = stage_q.aluctrl1;
  assign ex_valid      = stage_q.valid;
  assign ex_pc         = stage_q.pc;
  assign ex_rd         = stage_q.rd;
  assign ex_regwrite   = stage_q.regwrite;
  assign ex_memread    = stage_q.memread;
  assign ex_memwrite   = stage_q.memwrite;

  assign load_use = stage_q.valid && stage_q.memread && stage_q.rd != 5'd0 &&
                    (stage_q.rd == id_rs1 || stage_q.rd == id_rs2) && id_valid;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage: reset, forwarding, operand select,
// stall/flush, load-use detection and bubble insertion.
module tb_ex_operand_stage;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rstn;
  logic            stall, flush;
  logic            id_valid;
  logic [XLEN-1:0] id_pc;
  logic [4:0]      id_rs1, id_rs2, id_rd;
  logic [XLEN-1:0] id_rs1_data, id_rs2_data, id_imm;
  logic [1:0]      id_alusrc_a;
  logic            id_alusrc_b;
  logic [3:0]      id_aluctrl;
  logic [2:0]      id_aluctrl1;
  logic            id_regwrite, id_memread, id_memwrite;
  logic            exmem_regwrite;
  logic [4:0]      exmem_rd;
  logic [XLEN-1:0] exmem_result;
  logic            memwb_regwrite;
  logic [4:0]      memwb_rd;
  logic [XLEN-1:0] memwb_result;
  logic [XLEN-1:0] a, b, ex_pc, ex_store_data;
  logic [4:0]      shamt, ex_rd;
  logic [3:0]      aluctrl;
  logic [2:0]      aluctrl1;
  logic            ex_valid, ex_regwrite, ex_memread, ex_memwrite, load_use;

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  ex_operand_stage #(.XLEN(XLEN)) dut (
    .clk(clk), .rstn(rstn), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_alusrc_a(id_alusrc_a), .id_alusrc_b(id_alusrc_b),
    .id_aluctrl(id_aluctrl), .id_aluctrl1(id_aluctrl1),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
    .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .a(a), .b(b), .shamt(shamt), .aluctrl(aluctrl), .aluctrl1(aluctrl1),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rd(ex_rd), .ex_store_data(ex_store_data),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
    .load_use(load_use)
  );

  task automatic set_id(
    input logic v, input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
    input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
    input logic [1:0] sa, input logic sb, input logic [3:0] ctl, input logic [2:0] ctl1,
    input logic rw, input logic mr, input logic mw);
    id_valid = v; id_pc = pc; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_rs1_data = d1; id_rs2_data = d2; id_imm = imm;
    id_alusrc_a = sa; id_alusrc_b = sb; id_aluctrl = ctl; id_aluctrl1 = ctl1;
    id_regwrite = rw; id_memread = mr; id_memwrite = mw;
  endtask

  task automatic clear_fwd();
    exmem_regwrite = 0; exmem_rd = 0; exmem_result = 0;
    memwb_regwrite = 0; memwb_rd = 0; memwb_result = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rstn = 0; stall = 0; flush = 0; clear_fwd();
    set_id(1, 32'h80, 5'd3, 5'd4, 5'd6, 32'h1234, 32'h5678, 32'h9, 2'b01, 1'b1, 4'h7, 3'b010, 1, 1, 1);
    tick(); tick();
    rstn = 1;
    tick();
    total++;
    if (ex_valid !== 1'b1 || aluctrl !== 4'h7) begin
      $display("FAIL reset_preload: ex_valid=%b aluctrl=%h want 1/7", ex_valid, aluctrl);
    end else pass_cnt++;
    #2 rstn = 0;
    #1;
    total++;
    if ({ex_valid, aluctrl, aluctrl1, ex_regwrite, ex_memread, ex_memwrite} !== 13'd0 ||
        a !== 0 || b !== 0 || shamt !== 0 || ex_store_data !== 0 || ex_pc !== 0 ||
        ex_rd !== 0 || load_use !== 0) begin
      $display("FAIL reset_async: v=%b ctl=%h ctl1=%h a=%h b=%h sh=%h sd=%h pc=%h rd=%0d lu=%b want all 0",
               ex_valid, aluctrl, aluctrl1, a, b, shamt, ex_store_data, ex_pc, ex_rd, load_use);
    end else pass_cnt++;
    #1 rstn = 1;
    set_id(1, 32'h0, 5'd0, 5'd0, 5'd1, 32'h0, 32'h0, 32'h0, 2'b00, 1'b0, 4'h1, 3'b000, 1, 0, 0);
    tick();
    total++;
    if (aluctrl !== 4'h1 || ex_valid !== 1'b1) begin
      $display("FAIL reset_release: aluctrl=%h ex_valid=%b want 1/1", aluctrl, ex_valid);
    end else pass_cnt++;
  endtask

  task automatic test_forward();
    clear_fwd();
    set_id(1, 32'h0, 5'd5, 5'd6, 5'd1, 32'h11, 32'h22, 32'h0, 2'b00, 1'b0, 4'h2, 3'b000, 1, 0, 0);
    tick();
    exmem_regwrite = 1; exmem_rd = 5; exmem_result = 32'hAA;
    memwb_regwrite = 1; memwb_rd = 5; memwb_result = 32'hBB;
    #1;
    total++;
    if (a !== 32'hAA) $display("FAIL fwd_exmem_prio: a=%h want aa", a);
    else pass_cnt++;
    exmem_regwrite = 0; #1;
    total++;
    if (a !== 32'hBB) $display("FAIL fwd_memwb: a=%h want bb", a);
    else pass_cnt++;
    exmem_regwrite = 1; exmem_rd = 0; memwb_rd = 0; #1;
    total++;
    if (a !== 32'h11) $display("FAIL fwd_x0: a=%h want 11", a);
    else pass_cnt++;
    memwb_rd = 6; #1;
    total++;
    if (b !== 32'hBB || ex_store_data !== 32'hBB || a !== 32'h11)
      $display("FAIL fwd_rs2: b=%h sd=%h a=%h want bb/bb/11", b, ex_store_data, a);
    else pass_cnt++;
    clear_fwd();
  endtask

  task automatic test_operand_select();
    set_id(1, 32'h100, 5'd3, 5'd4, 5'd2, 32'h33, 32'h44, 32'hFFFFFFF3, 2'b01, 1'b1, 4'h3, 3'b000, 1, 0, 0);
    tick();
    total++;
    if (a !== 32'h100 || b !== 32'hFFFFFFF3 || shamt !== 5'h13 || ex_store_data !== 32'h44)
      $display("FAIL opsel_pc_imm: a=%h b=%h sh=%h sd=%h want 100/fffffff3/13/44", a, b, shamt, ex_store_data);
    else pass_cnt++;
    id_aluctrl1 = 3'b001;
    tick();
    total++;
    if (b !== 32'h44 || shamt !== 5'h04 || aluctrl1 !== 3'b001)
      $display("FAIL opsel_branch_b: b=%h sh=%h ctl1=%h want 44/04/1", b, shamt, aluctrl1);
    else pass_cnt++;
    id_aluctrl1 = 3'b000; id_alusrc_a = 2'b10;
    tick();
    total++;
    if (a !== 32'h0 || b !== 32'hFFFFFFF3) $display("FAIL opsel_zero_a: a=%h b=%h want 0/fffffff3", a, b);
    else pass_cnt++;
    id_alusrc_a = 2'b11; id_alusrc_b = 1'b0;
    tick();
    total++;
    if (a !== 32'h0 || b !== 32'h44) $display("FAIL opsel_rsvd_a: a=%h b=%h want 0/44", a, b);
    else pass_cnt++;
    id_alusrc_a = 2'b00;
    tick();
    total++;
    if (a !== 32'h33) $display("FAIL opsel_rs1: a=%h want 33", a);
    else pass_cnt++;
  endtask

  task automatic test_stall_flush();
    set_id(1, 32'h200, 5'd10, 5'd0, 5'd9, 32'h55, 32'h0, 32'h0, 2'b00, 1'b0, 4'h6, 3'b000, 1, 0, 0);
    tick();
    stall = 1;
    set_id(1, 32'h300, 5'd11, 5'd12, 5'd3, 32'h66, 32'h1, 32'h2, 2'b01, 1'b1, 4'h7, 3'b011, 0, 1, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (ex_pc !== 32'h200 || ex_rd !== 5'd9 || aluctrl !== 4'h6 || ex_regwrite !== 1'b1 ||
          ex_valid !== 1'b1 || a !== 32'h55 || ex_memread !== 1'b0)
        $display("FAIL stall_hold[%0d]: pc=%h rd=%0d ctl=%h rw=%b v=%b a=%h mr=%b want 200/9/6/1/1/55/0",
                 i, ex_pc, ex_rd, aluctrl, ex_regwrite, ex_valid, a, ex_memread);
      else pass_cnt++;
      id_pc = id_pc + 32'h4;
    end
    memwb_regwrite = 1; memwb_rd = 10; memwb_result = 32'h77; #1;
    total++;
    if (a !== 32'h77) $display("FAIL stall_live_fwd: a=%h want 77", a);
    else pass_cnt++;
    flush = 1;
    tick();
    total++;
    if (ex_valid !== 1'b0 || aluctrl !== 4'h0 || ex_regwrite !== 1'b0 || ex_pc !== 32'h0 || ex_rd !== 5'd0)
      $display("FAIL flush_over_stall: v=%b ctl=%h rw=%b pc=%h rd=%0d want 0", ex_valid, aluctrl, ex_regwrite, ex_pc, ex_rd);
    else pass_cnt++;
    flush = 0; stall = 0; clear_fwd();
  endtask

  task automatic test_load_use();
    set_id(1, 32'h0, 5'd1, 5'd2, 5'd7, 32'h0, 32'h0, 32'h4, 2'b00, 1'b1, 4'h0, 3'b000, 1, 1, 0);
    tick();
    id_rs1 = 5'd1; id_rs2 = 5'd7; id_memread = 0; #1;
    total++;
    if (load_use !== 1'b1) $display("FAIL load_use_rs2: load_use=%b want 1", load_use);
    else pass_cnt++;
    id_rs1 = 5'd7; id_rs2 = 5'd8; #1;
    total++;
    if (load_use !== 1'b1) $display("FAIL load_use_rs1: load_use=%b want 1", load_use);
    else pass_cnt++;
    id_valid = 0; #1;
    total++;
    if (load_use !== 1'b0) $display("FAIL load_use_id_invalid: load_use=%b want 0", load_use);
    else pass_cnt++;
    set_id(1, 32'h0, 5'd1, 5'd2, 5'd0, 32'h0, 32'h0, 32'h4, 2'b00, 1'b1, 4'h0, 3'b000, 1, 1, 0);
    tick();
    id_rs1 = 5'd0; id_rs2 = 5'd0; #1;
    total++;
    if (load_use !== 1'b0 || ex_memread !== 1'b1) $display("FAIL load_use_x0: load_use=%b mr=%b want 0/1", load_use, ex_memread);
    else pass_cnt++;
  endtask

  task automatic test_bubble();
    set_id(0, 32'h400, 5'd1, 5'd2, 5'd4, 32'h9, 32'h8, 32'h7, 2'b00, 1'b0, 4'h5, 3'b011, 1, 1, 1);
    tick();
    total++;
    if (ex_regwrite !== 1'b0 || aluctrl !== 4'h0 || ex_valid !== 1'b0 || aluctrl1 !== 3'b000 ||
        ex_memread !== 1'b0 || ex_memwrite !== 1'b0 || ex_pc !== 32'h400)
      $display("FAIL bubble: rw=%b ctl=%h v=%b ctl1=%h mr=%b mw=%b pc=%h want 0/0/0/0/0/0/400",
               ex_regwrite, aluctrl, ex_valid, aluctrl1, ex_memread, ex_memwrite, ex_pc);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 3; i++) begin
      set_id(1, 32'h500 + 32'(i * 4), 5'd0, 5'd0, 5'(i), 32'h0, 32'h0, 32'h0, 2'b01, 1'b0, 4'(i + 8), 3'b000, 1, 0, 0);
      tick();
      total++;
      if (aluctrl !== 4'(i + 8) || a !== 32'h500 + 32'(i * 4) || ex_rd !== 5'(i))
        $display("FAIL back_to_back[%0d]: ctl=%h a=%h rd=%0d want %h/%h/%0d",
                 i, aluctrl, a, ex_rd, i + 8, 32'h500 + i * 4, i);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_operand_select();
    test_stall_flush();
    test_load_use();
    test_bubble();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
